// File: rtl/sensor_alarm_array_if.sv
// Sensor/buzzer bundle for the sensor alarm array.
// master = tile side driving sensors, slave = alarm controller.
interface sensor_alarm_array_if #(
    parameter int N_CH = 3
);
    localparam int ID_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic            ena;
    logic [N_CH-1:0] sensor;
    logic            mode;
    logic            ack;
    logic [N_CH-1:0] buzzer;
    logic [ID_W-1:0] active_id;
    logic            busy;
    logic [N_CH-1:0] pending;

    modport master (
        output ena, sensor, mode, ack,
        input  buzzer, active_id, busy, pending
    );

    modport slave (
        input  ena, sensor, mode, ack,
        output buzzer, active_id, busy, pending
    );
endinterface

// File: rtl/sensor_alarm_array.sv
// N-channel debounced sensor alarm controller.
// Serves queued events lowest channel first: alarm, then re-arm holdoff.
module sensor_alarm_array #(
    parameter int N_CH           = 3,
    parameter int DEB_CYCLES     = 7,
    parameter int ALARM_CYCLES   = 31,
    parameter int HOLDOFF_CYCLES = 4
) (
    input logic                 clk,
    input logic                 rst,
    sensor_alarm_array_if.slave bus
);
    localparam int ID_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam int T_AH  = (ALARM_CYCLES > HOLDOFF_CYCLES) ?
                           ALARM_CYCLES : HOLDOFF_CYCLES;
    localparam int T_MAX = (T_AH > 2) ? T_AH : 2;
    localparam int TMR_W = $clog2(T_MAX);

    localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEB_CYCLES);
    localparam logic [CNT_W-1:0] DEB_QUAL = CNT_W'(DEB_CYCLES - 1);
    localparam logic [TMR_W-1:0] ALARM_LD = TMR_W'(ALARM_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LD  =
        TMR_W'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);
    localparam bit HAS_HOLD = (HOLDOFF_CYCLES > 0);

    typedef enum logic [1:0] {
        IDLE,
        ALARM,
        HOLDOFF
    } state_t;

    state_t          state, state_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic            mode_q, mode_nxt;
    logic [N_CH-1:0] buzzer_q, buzzer_nxt;
    logic [ID_W-1:0] id_q, id_nxt;
    logic            busy_q, busy_nxt;
    logic [N_CH-1:0] pend_q, pend_nxt;
    logic [N_CH-1:0] qual;
    logic [N_CH-1:0] gmask;
    logic [ID_W-1:0] gnt_idx;
    logic            gnt_any;
    logic [CNT_W-1:0] cnt     [N_CH];
    logic [CNT_W-1:0] cnt_nxt [N_CH];

    // Qualify fires on the sample that would reach DEB_CYCLES, once per high run.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            qual[i] = bus.sensor[i] && (cnt[i] == DEB_QUAL);
            if (!bus.sensor[i]) begin
                cnt_nxt[i] = '0;
            end else if (cnt[i] == DEB_MAX) begin
                cnt_nxt[i] = cnt[i];
            end else begin
                cnt_nxt[i] = cnt[i] + CNT_W'(1);
            end
        end
    end

    // Descending scan so the lowest set index wins.
    always_comb begin
        gnt_any = |pend_q;
        gnt_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (pend_q[i]) gnt_idx = ID_W'(i);
        end
    end

    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        mode_nxt   = mode_q;
        buzzer_nxt = buzzer_q;
        id_nxt     = id_q;
        busy_nxt   = busy_q;
        gmask      = '0;
        unique case (state)
            IDLE: begin
                if (gnt_any) begin
                    gmask      = N_CH'(1) << gnt_idx;
                    buzzer_nxt = N_CH'(1) << gnt_idx;
                    id_nxt     = gnt_idx;
                    mode_nxt   = bus.mode;
                    timer_nxt  = ALARM_LD;
                    busy_nxt   = 1'b1;
                    state_nxt  = ALARM;
                end
            end
            ALARM: begin
                if (bus.ack || (!mode_q && timer == '0)) begin
                    buzzer_nxt = '0;
                    id_nxt     = '0;
                    if (HAS_HOLD) begin
                        timer_nxt = HOLD_LD;
                        state_nxt = HOLDOFF;
                    end else begin
                        busy_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end
                end else if (timer != '0) begin
                    timer_nxt = timer - TMR_W'(1);
                end
            end
            HOLDOFF: begin
                if (timer == '0) begin
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer - TMR_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        pend_nxt = (pend_q & ~gmask) | qual;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            timer    <= '0;
            mode_q   <= 1'b0;
            buzzer_q <= '0;
            id_q     <= '0;
            busy_q   <= 1'b0;
            pend_q   <= '0;
            for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
        end else if (bus.ena) begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            mode_q   <= mode_nxt;
            buzzer_q <= buzzer_nxt;
            id_q     <= id_nxt;
            busy_q   <= busy_nxt;
            pend_q   <= pend_nxt;
            for (int i = 0; i < N_CH; i++) cnt[i] <= cnt_nxt[i];
        end
    end

    assign bus.buzzer    = buzzer_q;
    assign bus.active_id = id_q;
    assign bus.busy      = busy_q;
    assign bus.pending   = pend_q;
endmodule

// File: tb/tb_sensor_alarm_array.sv
// Directed self-checking bench for sensor_alarm_array (default parameters).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_sensor_alarm_array;
    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   n;
    int   g;

    sensor_alarm_array_if #(.N_CH(3)) bus ();

    sensor_alarm_array #(
        .N_CH(3),
        .DEB_CYCLES(7),
        .ALARM_CYCLES(31),
        .HOLDOFF_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        bus.sensor = 3'b000;
        bus.mode   = 1'b0;
        bus.ack    = 1'b0;
        bus.ena    = 1'b1;
        rst        = 1'b1;
        step();
        rst        = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;

        // 1: reset with sensors high, then first alarm at 8th edge
        rst        = 1'b1;
        bus.ena    = 1'b1;
        bus.sensor = 3'b111;
        bus.mode   = 1'b0;
        bus.ack    = 1'b0;
        repeat (2) step();
        chk("rst_buzzer", 32'(bus.buzzer), 32'h0);
        chk("rst_pending", 32'(bus.pending), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_id", 32'(bus.active_id), 32'h0);
        rst = 1'b0;
        repeat (7) step();
        chk("t1_buz_edge7", 32'(bus.buzzer), 32'h0);
        chk("t1_pend_edge7", 32'(bus.pending), 32'h7);
        step();
        chk("t1_buz_edge8", 32'(bus.buzzer), 32'h1);
        chk("t1_pend_edge8", 32'(bus.pending), 32'h6);

        // 2: short burst rejected, full burst gives 31-cycle alarm
        do_reset();
        bus.sensor = 3'b010;
        repeat (6) step();
        bus.sensor = 3'b000;
        step();
        chk("t2_no_event", 32'(bus.pending), 32'h0);
        chk("t2_idle", 32'(bus.busy), 32'h0);
        bus.sensor = 3'b010;
        repeat (7) step();
        chk("t2_pend", 32'(bus.pending), 32'h2);
        step();
        chk("t2_buz", 32'(bus.buzzer), 32'h2);
        chk("t2_id", 32'(bus.active_id), 32'h1);
        n = 0;
        while (bus.buzzer == 3'b010 && n < 200) begin
            n++;
            step();
        end
        chk("t2_alarm_len", 32'(n), 32'd31);
        while (bus.busy && n < 300) begin
            n++;
            step();
        end
        chk("t2_busy_len", 32'(n), 32'd35);
        bus.sensor = 3'b000;

        // 3: simultaneous ch2/ch0, lowest first, 5-cycle gap
        do_reset();
        bus.sensor = 3'b101;
        repeat (8) step();
        chk("t3_buz0", 32'(bus.buzzer), 32'h1);
        chk("t3_pend", 32'(bus.pending), 32'h4);
        n = 0;
        while (bus.buzzer == 3'b001 && n < 200) begin
            if (n == 15) chk("t3_pend_mid", 32'(bus.pending), 32'h4);
            n++;
            step();
        end
        chk("t3_alarm_len", 32'(n), 32'd31);
        g = 0;
        while (bus.buzzer == 3'b000 && g < 50) begin
            g++;
            step();
        end
        chk("t3_gap", 32'(g), 32'd5);
        chk("t3_buz2", 32'(bus.buzzer), 32'h4);
        chk("t3_id2", 32'(bus.active_id), 32'h2);

        // 4: latched mode ends only on ack; mode change mid-alarm ignored
        do_reset();
        bus.mode   = 1'b1;
        bus.sensor = 3'b001;
        repeat (8) step();
        chk("t4_buz", 32'(bus.buzzer), 32'h1);
        bus.mode = 1'b0;
        repeat (100) step();
        chk("t4_latched", 32'(bus.buzzer), 32'h1);
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        chk("t4_ack_buz", 32'(bus.buzzer), 32'h0);
        chk("t4_ack_id", 32'(bus.active_id), 32'h0);
        n = 0;
        while (bus.busy && n < 50) begin
            n++;
            step();
        end
        chk("t4_holdoff", 32'(n), 32'd4);

        // 5: ena low for 10 cycles stretches the alarm to 41 cycles
        do_reset();
        bus.sensor = 3'b001;
        repeat (8) step();
        n = 0;
        repeat (5) begin
            n++;
            step();
        end
        bus.ena = 1'b0;
        repeat (10) begin
            n++;
            step();
        end
        chk("t5_frz_buz", 32'(bus.buzzer), 32'h1);
        chk("t5_frz_busy", 32'(bus.busy), 32'h1);
        chk("t5_frz_pend", 32'(bus.pending), 32'h0);
        chk("t5_frz_id", 32'(bus.active_id), 32'h0);
        bus.ena = 1'b1;
        while (bus.buzzer == 3'b001 && n < 200) begin
            n++;
            step();
        end
        chk("t5_span", 32'(n), 32'd41);

        // 6: reset mid-alarm clears everything, nothing resumes
        do_reset();
        bus.sensor = 3'b111;
        repeat (8) step();
        chk("t6_buz", 32'(bus.buzzer), 32'h1);
        repeat (9) step();
        chk("t6_pend", 32'(bus.pending), 32'h6);
        rst        = 1'b1;
        bus.sensor = 3'b000;
        step();
        rst = 1'b0;
        chk("t6_rst_buz", 32'(bus.buzzer), 32'h0);
        chk("t6_rst_pend", 32'(bus.pending), 32'h0);
        chk("t6_rst_busy", 32'(bus.busy), 32'h0);
        chk("t6_rst_id", 32'(bus.active_id), 32'h0);
        repeat (50) step();
        chk("t6_quiet_buz", 32'(bus.buzzer), 32'h0);
        chk("t6_quiet_busy", 32'(bus.busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sensor_alarm_array.md
# sensor_alarm_array

Parametrised N-channel sensor alarm controller. Each sensor input is debounced independently. A qualified sensor event is queued in a pending mask. Pending events are served one at a time, lowest channel first, by driving that channel's buzzer for a timed or acknowledge-terminated alarm, followed by a re-arm holdoff. The block sits between the raw sensor pins and the buzzer drivers in the top-level tile.

## Interface

Parameters:
- N_CH, 3: number of sensor/buzzer channels, 1..8.
- DEB_CYCLES, 7: consecutive high samples needed to qualify an event, ≥1.
- ALARM_CYCLES, 31: alarm length in mode 0, ≥1.
- HOLDOFF_CYCLES, 4: buzzer-off gap after each alarm, ≥0. A value of 0 skips HOLDOFF.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- ena  in  1  clock enable; when low, every register holds.
- sensor  in  N_CH  raw sensor levels, active-high.
- mode  in  1  0 = timed alarm, 1 = latched until ack.
- ack  in  1  single-cycle acknowledge; ends the current alarm.
- buzzer  out  N_CH  one-hot or zero; the active alarm channel.
- active_id  out  clog2(N_CH) (min 1)  index of the served channel; 0 when idle.
- busy  out  1  high in ALARM or HOLDOFF.
- pending  out  N_CH  queued, unserved events.

## Operation

Debounce, per channel:
- Counter cnt[i] has width clog2(DEB_CYCLES+1).
- A high sample increments cnt[i], saturating at DEB_CYCLES. A low sample clears it to 0.
- qual[i] = sensor[i] & (cnt[i] == DEB_CYCLES-1). This is one pulse per continuous assertion.
- To re-qualify, the sensor must return low.
- Debounce runs in every FSM state.

Pending mask:
- pending <= (pending & ~grant_mask) | qual. Set wins over clear on the same bit.

FSM states: IDLE, ALARM, HOLDOFF.
- **IDLE:** if pending ≠ 0, grant the lowest set index g.
  - Clear pending[g], set buzzer = 1<<g, set active_id = g.
  - Latch mode into mode_q, load timer = ALARM_CYCLES-1, go to ALARM.
- **ALARM:** buzzer held.
  - Exit when ack=1 (either mode).
  - Also exit when mode_q=0 and timer==0; otherwise decrement timer.
  - On exit: buzzer=0, active_id=0.
  - If HOLDOFF_CYCLES>0: load timer = HOLDOFF_CYCLES-1 and go to HOLDOFF. Otherwise go to IDLE.
- **HOLDOFF:** buzzer=0. When timer==0 go to IDLE, else decrement.
- Changing `mode` mid-alarm has no effect; mode_q governs.
- `ack` in IDLE or HOLDOFF is ignored.
- New qualifications during ALARM or HOLDOFF only set pending.
- The timer is a single shared counter of width clog2(max(ALARM_CYCLES, HOLDOFF_CYCLES, 2)).

Reset (rst=1 at an edge with ena irrelevant):
- FSM goes to IDLE.
- cnt, pending, timer, mode_q, buzzer, active_id and busy all go to 0.
- Reset has priority over ena and over any in-progress alarm.

## Timing

- Sensor rises before edge E0 and stays high: qual is high in the cycle before edge E0+DEB_CYCLES-1.
  - pending[i] is set at that edge.
  - buzzer[i] rises at edge E0+DEB_CYCLES (IDLE case).
  - For DEB_CYCLES=7: 8 edges from the first high sample edge to buzzer high.
- Mode 0: buzzer stays high for exactly ALARM_CYCLES enabled cycles.
- Mode 1: buzzer falls at the edge that samples ack=1.
- Holdoff: exactly HOLDOFF_CYCLES enabled cycles with buzzer=0 before the next grant can occur. The next buzzer rises at the edge after the IDLE cycle.
- A back-to-back grant requires one IDLE cycle.
- Gap between alarms: HOLDOFF_CYCLES+1 cycles.
- ena=0 cycles do not count toward any counter. Outputs are frozen during ena=0.
- All outputs are registered. No combinational path exists from inputs to outputs.

## Test plan

1. rst=1 for 2 cycles with sensor=3'b111 → buzzer=0, pending=0, busy=0, active_id=0.
   - Release rst with sensor held → buzzer=3'b001 at the 8th edge.
2. sensor[1] high for 6 cycles, low for 1, high for 7, with defaults →
   - no event from the first burst;
   - buzzer=3'b010 for exactly 31 cycles;
   - busy stays high for 35 cycles total.
3. sensor[2] and sensor[0] qualify in the same cycle →
   - buzzer=001 for 31 cycles, with pending=100 during it;
   - 4-cycle holdoff, 1 IDLE cycle;
   - then buzzer=100 and active_id=2.
4. mode=1, sensor[0] qualifies, no ack for 100 cycles → buzzer stays 001. Pulse ack → buzzer=0 at the next edge, and busy holds for 4 more cycles.
5. Mode 0 alarm with ena held low for 10 cycles mid-alarm → total buzzer-high span is 41 clk cycles. All outputs are constant while ena=0.
6. rst asserted on cycle 10 of an alarm with pending=110 → all outputs 0 at the next edge. No alarm resumes while sensors are held low.
